// File: rtl/rv32i_alu_unit_if.sv
// Execute-stage ALU bus: captured operands/opcode in, registered result/branch flag out.
// Zero flag exists only when ALU_ZERO_FLAG_EN is defined.
interface rv32i_alu_unit_if;
  logic        in_valid;
  logic [6:0]  Opcode;
  logic [3:0]  FuncCode;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUOut;
  logic        Branch_Enable;
  logic        out_valid;
`ifdef ALU_ZERO_FLAG_EN
  logic        Zero;

  modport master (output in_valid, Opcode, FuncCode, A, B,
                  input  ALUOut, Branch_Enable, out_valid, Zero);
  modport slave  (input  in_valid, Opcode, FuncCode, A, B,
                  output ALUOut, Branch_Enable, out_valid, Zero);
`else
  modport master (output in_valid, Opcode, FuncCode, A, B,
                  input  ALUOut, Branch_Enable, out_valid);
  modport slave  (input  in_valid, Opcode, FuncCode, A, B,
                  output ALUOut, Branch_Enable, out_valid);
`endif
endinterface

// File: rtl/rv32i_alu_unit.sv
// RV32I ALU-control decode + ALU, one-cycle registered result; no backpressure, in_valid alone qualifies.
// Optional registered Zero flag under ALU_ZERO_FLAG_EN.
module rv32i_alu_unit #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  rv32i_alu_unit_if.slave  bus
);

  typedef enum logic [6:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_BR
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  alu_ctrl_e        alu_ctrl;
  logic [2:0]       funct3;
  logic             alt;
  logic [4:0]       shamt;
  logic [XLEN-1:0]  diff;
  logic [XLEN-1:0]  result;
  logic             br_taken;

  logic [XLEN-1:0]  alu_out_d, alu_out_q;
  logic             br_en_d, br_en_q;
  logic             out_vld_d, out_vld_q;

  assign funct3 = bus.FuncCode[2:0];
  assign alt    = bus.FuncCode[3];
  assign shamt  = bus.B[4:0];
  assign diff   = bus.A - bus.B;

  always_comb begin
    alu_ctrl = ALU_ZERO;
    case (bus.Opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3)
          3'b000:  alu_ctrl = (alt && bus.Opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR: alu_ctrl = ALU_ADD;
      OPC_LUI:    alu_ctrl = ALU_PASSB;
      OPC_BRANCH: alu_ctrl = ALU_BR;
      default:    alu_ctrl = ALU_ZERO;
    endcase
  end

  always_comb begin
    result   = '0;
    br_taken = 1'b0;
    case (alu_ctrl)
      ALU_ADD:   result = bus.A + bus.B;
      ALU_SUB:   result = diff;
      ALU_SLL:   result = bus.A << shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (bus.A < bus.B)};
      ALU_XOR:   result = bus.A ^ bus.B;
      ALU_SRL:   result = bus.A >> shamt;
      ALU_SRA:   result = $unsigned($signed(bus.A) >>> shamt);
      ALU_OR:    result = bus.A | bus.B;
      ALU_AND:   result = bus.A & bus.B;
      ALU_PASSB: result = bus.B;
      ALU_BR: begin
        result = diff;
        case (funct3)
          3'b000:  br_taken = (bus.A == bus.B);
          3'b001:  br_taken = (bus.A != bus.B);
          3'b100:  br_taken = ($signed(bus.A) <  $signed(bus.B));
          3'b101:  br_taken = ($signed(bus.A) >= $signed(bus.B));
          3'b110:  br_taken = (bus.A <  bus.B);
          3'b111:  br_taken = (bus.A >= bus.B);
          default: br_taken = 1'b0;
        endcase
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    alu_out_d = alu_out_q;
    br_en_d   = br_en_q;
    out_vld_d = bus.in_valid;
    if (bus.in_valid) begin
      alu_out_d = result;
      br_en_d   = br_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      br_en_q   <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      br_en_q   <= br_en_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bus.ALUOut        = alu_out_q;
  assign bus.Branch_Enable = br_en_q;
  assign bus.out_valid     = out_vld_q;

`ifdef ALU_ZERO_FLAG_EN
  logic zero_d, zero_q;

  assign zero_d = bus.in_valid ? (result == '0) : zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_q <= 1'b0;
    else        zero_q <= zero_d;
  end

  assign bus.Zero = zero_q;
`endif

endmodule

// File: tb/tb_rv32i_alu_unit.sv
// Scoreboard bench for rv32i_alu_unit: expected results queued at drive time, popped when out_valid rises.
module tb_rv32i_alu_unit;

  typedef struct {
    logic [31:0] alu;
    logic        br;
  } exp_t;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  rv32i_alu_unit_if bus ();

  rv32i_alu_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input logic [3:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    int   sh;
    m.alu = 32'h0;
    m.br  = 1'b0;
    sh    = int'(b % 32);
    if (op == R || op == I) begin
      case (f[2:0])
        3'd0: m.alu = (op == R && f[3]) ? a - b : a + b;
        3'd1: m.alu = a << sh;
        3'd2: m.alu = (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
        3'd3: m.alu = (a < b) ? 32'd1 : 32'd0;
        3'd4: m.alu = a ^ b;
        3'd5: m.alu = f[3] ? 32'(signed'(a) >>> sh) : a >> sh;
        3'd6: m.alu = a | b;
        default: m.alu = a & b;
      endcase
    end else if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0010111 ||
                 op == 7'b1101111 || op == 7'b1100111) begin
      m.alu = a + b;
    end else if (op == LUI) begin
      m.alu = b;
    end else if (op == BR) begin
      m.alu = a - b;
      case (f[2:0])
        3'd0: m.br = (a == b);
        3'd1: m.br = (a != b);
        3'd4: m.br = signed'(a) < signed'(b);
        3'd5: m.br = signed'(a) >= signed'(b);
        3'd6: m.br = a < b;
        3'd7: m.br = a >= b;
        default: m.br = 1'b0;
      endcase
    end
    return m;
  endfunction

  task automatic send(input logic [6:0] op, input logic [3:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ea, input logic eb);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.Opcode   = op;
    bus.FuncCode = f;
    bus.A        = a;
    bus.B        = b;
    e.alu = ea;
    e.br  = eb;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("alu_out", bus.ALUOut, e.alu);
        chk("branch_en", {31'b0, bus.Branch_Enable}, {31'b0, e.br});
`ifdef ALU_ZERO_FLAG_EN
        chk("zero", {31'b0, bus.Zero}, {31'b0, (e.alu == 32'h0)});
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[10];
    logic [6:0] op;
    logic [3:0] f;
    logic [31:0] a, b;
    exp_t m;
    ops = '{R, I, BR, LUI, 7'b0000011, 7'b0100011, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};

    bus.in_valid = 1'b0;
    bus.Opcode   = 7'h0;
    bus.FuncCode = 4'h0;
    bus.A        = 32'h0;
    bus.B        = 32'h0;

    #3;
    chk("rst_alu", bus.ALUOut, 32'h0);
    chk("rst_br", {31'b0, bus.Branch_Enable}, 32'h0);
    chk("rst_vld", {31'b0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_alu", bus.ALUOut, 32'h0);
    chk("post_rst_vld", {31'b0, bus.out_valid}, 32'h0);

    // Directed cases, issued back-to-back
    send(R, 4'b0111, 32'h4F, 32'h55, 32'h45, 1'b0);
    send(R, 4'b0110, 32'h0F, 32'h55, 32'h5F, 1'b0);
    send(R, 4'b0100, 32'h55, 32'hFF, 32'hAA, 1'b0);
    send(R, 4'b1111, 32'h4F, 32'h55, 32'h45, 1'b0);
    send(R, 4'b1000, 32'd10000, 32'd111, 32'd9889, 1'b0);
    send(R, 4'b0000, 32'd10000, 32'd111, 32'd10111, 1'b0);
    send(R, 4'b0010, 32'd0, 32'd2, 32'd1, 1'b0);
    send(R, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    send(R, 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    send(R, 4'b0101, 32'd16, 32'd2, 32'd4, 1'b0);
    send(R, 4'b1101, 32'd8, 32'd1, 32'd4, 1'b0);
    send(R, 4'b1101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
    send(R, 4'b0001, 32'd2, 32'd2, 32'd8, 1'b0);
    send(R, 4'b0001, 32'd2, 32'd33, 32'd4, 1'b0);
    send(BR, 4'b0000, 32'd5, 32'd5, 32'd0, 1'b1);
    send(BR, 4'b0001, 32'd5, 32'd5, 32'd0, 1'b0);
    send(BR, 4'b0100, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b1);
    send(BR, 4'b0110, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0);
    send(BR, 4'b0010, 32'd1, 32'd2, 32'hFFFFFFFF, 1'b0);
    send(BR, 4'b0101, 32'd3, 32'd3, 32'd0, 1'b1);
    send(BR, 4'b0111, 32'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    send(I, 4'b1000, 32'd7, 32'd3, 32'd10, 1'b0);
    send(I, 4'b1101, 32'h80000000, 32'd1, 32'hC0000000, 1'b0);
    send(LUI, 4'b0000, 32'd99, 32'h12345000, 32'h12345000, 1'b0);
    send(7'b1111111, 4'b0000, 32'd5, 32'd5, 32'd0, 1'b0);
    send(7'b1101111, 4'b0000, 32'd100, 32'd8, 32'd108, 1'b0);
    idle();
    drain();

    // in_valid low must hold the last result
    repeat (3) @(negedge clk);
    chk("hold_alu", bus.ALUOut, last_exp.alu);
    chk("hold_vld", {31'b0, bus.out_valid}, 32'h0);

    // Random burst, mixing gaps and back-to-back issue
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 9)];
      f  = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
      m  = model(op, f, a, b);
      send(op, f, a, b, m.alu, m.br);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();

    // Reset mid-cycle with a capture pending: result discarded
    send(R, 4'b0110, 32'h1234, 32'h1, 32'h1235, 1'b0);
    @(negedge clk);
    bus.Opcode = R;
    bus.A      = 32'hAAAA;
    bus.B      = 32'h5555;
    bus.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_alu", bus.ALUOut, 32'h0);
    chk("midrst_br", {31'b0, bus.Branch_Enable}, 32'h0);
    chk("midrst_vld", {31'b0, bus.out_valid}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_midrst_alu", bus.ALUOut, 32'h0);
    chk("after_midrst_vld", {31'b0, bus.out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rv32i_alu_unit.md
Name: rv32i_alu_unit

Overview:
- RV32I execute-stage arithmetic block: ALU-control decoder plus ALU.
- The decoder maps opcode and {instr[30], funct3} to an internal 7-bit ALU control code.
- The ALU computes the 32-bit result and the branch-taken flag.
- Results are registered: one-cycle latency from input capture to output. Sits between the decode/register-read stage and writeback/PC-select logic.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode are captured on this clk edge.
- Opcode  input  7  instruction bits [6:0].
- FuncCode  input  4  {instr[30], instr[14:12]}.
- A  input  32  operand A (rs1 / PC).
- B  input  32  operand B (rs2 / immediate).
- ALUOut  output  32  registered result.
- Branch_Enable  output  1  registered branch-taken flag.
- out_valid  output  1  high for one cycle when ALUOut/Branch_Enable are updated.

Behaviour:
- Reset (rst_n low, asynchronous): ALUOut=0, Branch_Enable=0, out_valid=0. Reset is held while low. Reset asserted mid-operation discards the pending result.
- Control decode is combinational from Opcode/FuncCode. The ALU is combinational. The output registers load at rising clk when in_valid=1.
- out_valid is registered in_valid. When in_valid=0, ALUOut and Branch_Enable hold their previous values.
- Any in_valid pattern is legal, including back-to-back every cycle; there is no handshake beyond in_valid.
- Opcode 0110011 (R-type), by FuncCode:
  - 0000 ADD; 1000 SUB (A-B, modulo 2^32).
  - x001 SLL; x010 SLT (signed, result 1/0); x011 SLTU (unsigned).
  - x100 XOR; 0101 SRL; 1101 SRA; x110 OR; x111 AND.
  - Bit 3 is ignored except for funct3 000 and 101.
- Opcode 0010011 (OP-IMM): same as R-type, except funct3 000 is always ADD (bit 3 ignored). Bit 3 selects SRA vs SRL for funct3 101.
- Shift amount is always B[4:0]. SRA replicates A[31].
- Opcodes 0000011 (load), 0100011 (store), 0010111 (AUIPC), 1101111 (JAL), 1100111 (JALR): ADD, A+B.
- Opcode 0110111 (LUI): ALUOut=B.
- Opcode 1100011 (branch): ALUOut=A-B. Branch_Enable by funct3:
  - 000 BEQ; 001 BNE.
  - 100 BLT (signed); 101 BGE (signed).
  - 110 BLTU; 111 BGEU.
  - 010/011 give 0.
- Branch_Enable is 0 for every non-branch opcode.
- Any other opcode: ALUOut=0, Branch_Enable=0.
- All arithmetic wraps modulo 2^32; there are no overflow or carry outputs.

Optional Feature:
- Macro ALU_ZERO_FLAG_EN.
- When defined: adds output port Zero (1 bit), registered with ALUOut. Zero=1 iff the captured result equals 0. Zero resets to 0 and updates only when in_valid=1.
- When undefined: no Zero port and no associated logic.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> ALUOut=0, Branch_Enable=0, out_valid=0 immediately; after release with in_valid=0, outputs stay 0.
- R-type logic, Opcode 0110011:
  - AND: A=0x4F, B=0x55, FuncCode 0111 -> ALUOut=0x45 one cycle later, out_valid pulses.
  - OR: A=0x0F, B=0x55, FuncCode 0110 -> 0x5F.
  - XOR: A=0x55, B=0xFF, FuncCode 0100 -> 0xAA.
- R-type arithmetic, Opcode 0110011:
  - SUB: A=10000, B=111, FuncCode 1000 -> 9889.
  - ADD: same operands, FuncCode 0000 -> 10111.
  - SLT: A=0, B=2, FuncCode 0010 -> 1.
  - SLT: A=0xFFFFFFFF, B=1 -> 1.
  - SLTU: same operands (A=0xFFFFFFFF, B=1) -> 0.
- Shifts, Opcode 0110011:
  - SRL: A=16, B=2, FuncCode 0101 -> 4.
  - SRA: A=8, B=1, FuncCode 1101 -> 4.
  - SRA: A=0x80000000, B=4 -> 0xF8000000.
  - SLL: A=2, B=2, FuncCode 0001 -> 8.
  - Shift with B=33 -> shift amount 1.
- Branches, Opcode 1100011:
  - BEQ: A=B=5 -> Branch_Enable=1.
  - BNE: A=B=5 -> 0.
  - BLT: A=0xFFFFFFFF, B=0 -> 1.
  - BLTU: same operands -> 0.
  - funct3 010 -> 0.
- Misc:
  - OP-IMM with FuncCode 1000 -> ADD.
  - LUI: B=0x12345000 -> ALUOut=0x12345000.
  - Unknown opcode 1111111 -> 0.
  - Back-to-back in_valid each cycle yields a result every cycle.
  - in_valid=0 holds the previous result.
